// File: rtl/twos_pkg.sv
// twos_pkg: shared types and helpers for the two's-complement pipeline.
//   mode_e       : 2-bit operation select (PASS / NEG / ABS / SMAG)
//   min_of(w)    : most-negative w-bit pattern (1 followed by w-1 zeros)
//   max_of(w)    : most-positive w-bit pattern (0 followed by w-1 ones)
// The helpers return 64 bits; callers truncate to their own width, so
// widths up to 64 are supported.
package twos_pkg;

  typedef enum logic [1:0] {
    MODE_PASS = 2'b00,
    MODE_NEG  = 2'b01,
    MODE_ABS  = 2'b10,
    MODE_SMAG = 2'b11
  } mode_e;

  function automatic logic [63:0] min_of(input int unsigned w);
    return 64'd1 << (w - 1);
  endfunction

  function automatic logic [63:0] max_of(input int unsigned w);
    return min_of(w) - 64'd1;
  endfunction

endpackage

// File: rtl/pipe_stage.sv
// pipe_stage: one valid/ready register slice.
//   clk, rst          : clock, synchronous active-high reset
//   in_valid/in_ready : upstream handshake, in_data captured on accept
//   out_valid/out_ready, out_data : downstream handshake, held while stalled
// in_ready is combinational on out_ready so a full slice can drain and
// refill in the same cycle (full throughput, no bubble).
module pipe_stage #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  logic         r_valid;
  logic [W-1:0] r_data;
  logic         w_load;

  assign in_ready  = !rst && (!r_valid || out_ready);
  assign w_load    = in_valid && in_ready;
  assign out_valid = r_valid;
  assign out_data  = r_data;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else if (w_load) begin
      r_valid <= 1'b1;
      r_data  <= in_data;
    end else if (out_ready) begin
      r_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/twos_comp_pipe.sv
// twos_comp_pipe: two-stage two's-complement unit (PASS/NEG/ABS/SMAG).
//   clk, rst                      : clock, synchronous active-high reset
//   in_valid/in_ready, in_data, in_mode : operand handshake
//   out_valid/out_ready           : result handshake
//   out_data  : result (unsigned magnitude in SMAG)
//   out_sign  : operand MSB
//   out_ovf   : NEG/ABS of the most-negative value
//   ovf_count : saturating count of delivered overflow results
// Build option: TWOS_SAT_EN makes overflowing NEG/ABS return MAX instead
// of wrapping to MIN.
module twos_comp_pipe
  import twos_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int OVF_CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_data,
  input  logic [1:0]           in_mode,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH-1:0]     out_data,
  output logic                 out_sign,
  output logic                 out_ovf,
  output logic [OVF_CNT_W-1:0] ovf_count
);

  localparam logic [WIDTH-1:0] L_MIN = WIDTH'(min_of(WIDTH));

  // S1 payload {mode, operand}, S2 payload {ovf, sign, result}
  logic             w_s1_valid;
  logic [WIDTH+1:0] w_s1_pl;
  logic             w_s2_in_ready;
  logic [WIDTH+1:0] w_s2_pl_in;
  logic [WIDTH+1:0] w_s2_pl;

  logic [1:0]       w_mode;
  logic [WIDTH-1:0] w_op;
  logic [WIDTH-1:0] w_neg;
  logic [WIDTH-1:0] w_neg_fix;
  logic [WIDTH-1:0] w_res;
  logic             w_is_min;
  logic             w_ovf;

  pipe_stage #(.W(WIDTH + 2)) u_s1 (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  ({in_mode, in_data}),
    .out_valid(w_s1_valid),
    .out_ready(w_s2_in_ready),
    .out_data (w_s1_pl)
  );

  assign w_mode   = w_s1_pl[WIDTH+1:WIDTH];
  assign w_op     = w_s1_pl[WIDTH-1:0];
  assign w_neg    = (~w_op) + WIDTH'(1'b1);
  assign w_is_min = (w_op == L_MIN);

`ifdef TWOS_SAT_EN
  localparam logic [WIDTH-1:0] L_MAX = WIDTH'(max_of(WIDTH));
  assign w_neg_fix = w_is_min ? L_MAX : w_neg;
`else
  // -MIN wraps back to MIN, which is exactly what w_neg already holds.
  assign w_neg_fix = w_neg;
`endif

  always_comb begin
    w_res = w_op;
    w_ovf = 1'b0;
    case (mode_e'(w_mode))
      MODE_PASS: w_res = w_op;
      MODE_NEG: begin
        w_res = w_neg_fix;
        w_ovf = w_is_min;
      end
      MODE_ABS: begin
        w_res = w_op[WIDTH-1] ? w_neg_fix : w_op;
        w_ovf = w_is_min;
      end
      // Raw negation: MIN becomes 2^(WIDTH-1), valid as unsigned.
      MODE_SMAG: w_res = w_op[WIDTH-1] ? w_neg : w_op;
      default:   w_res = w_op;
    endcase
  end

  assign w_s2_pl_in = {w_ovf, w_op[WIDTH-1], w_res};

  pipe_stage #(.W(WIDTH + 2)) u_s2 (
    .clk      (clk),
    .rst      (rst),
    .in_valid (w_s1_valid),
    .in_ready (w_s2_in_ready),
    .in_data  (w_s2_pl_in),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (w_s2_pl)
  );

  assign out_ovf  = w_s2_pl[WIDTH+1];
  assign out_sign = w_s2_pl[WIDTH];
  assign out_data = w_s2_pl[WIDTH-1:0];

  logic [OVF_CNT_W-1:0] r_ovf_cnt;

  always_ff @(posedge clk) begin
    if (rst)
      r_ovf_cnt <= '0;
    else if (out_valid && out_ready && out_ovf && (r_ovf_cnt != '1))
      r_ovf_cnt <= r_ovf_cnt + OVF_CNT_W'(1'b1);
  end

  assign ovf_count = r_ovf_cnt;

endmodule

// File: tb/tb_twos_comp_pipe.sv
module tb_twos_comp_pipe;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic [1:0] in_mode;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic       out_sign;
  logic       out_ovf;
  logic [1:0] ovf_count;

  int checks = 0;
  int errors = 0;

`ifdef TWOS_SAT_EN
  localparam logic [7:0] OVF_RES = 8'h7F;
`else
  localparam logic [7:0] OVF_RES = 8'h80;
`endif

  twos_comp_pipe #(.WIDTH(8), .OVF_CNT_W(2)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_mode(in_mode),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_sign(out_sign), .out_ovf(out_ovf),
    .ovf_count(ovf_count)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic do_reset;
    rst = 1'b1; in_valid = 1'b0;
    #1;
    chk("rst_in_ready", in_ready, 0);
    tick; tick;
    rst = 1'b0;
    #1;
  endtask

  // Independent integer model: {ovf, sign, data}
  function automatic logic [9:0] ref_model(input logic [1:0] m, input logic [7:0] d);
    int v, r;
    logic ovf;
    v = int'($signed(d));
    case (m)
      2'd0:    r = v;
      2'd1:    r = -v;
      default: r = (v < 0) ? -v : v;
    endcase
    ovf = (m == 2'd1 || m == 2'd2) && (r > 127);
    if (ovf) r = int'($signed(OVF_RES));
    return {ovf, d[7], r[7:0]};
  endfunction

  typedef struct {
    logic [1:0] mode;
    logic [7:0] data;
    logic [7:0] exp_data;
    logic       exp_sign;
    logic       exp_ovf;
  } vec_t;

  vec_t vecs[15];

  initial begin
    logic [1:0] exp_cnt;
    logic [9:0] q[$];
    logic [9:0] exp_r;
    logic [9:0] held;
    logic       stalled;
    int         occ;
    int         budget;

    vecs[0]  = '{2'd1, 8'h05, 8'hFB, 1'b0, 1'b0};
    vecs[1]  = '{2'd1, 8'hFB, 8'h05, 1'b1, 1'b0};
    vecs[2]  = '{2'd1, 8'h00, 8'h00, 1'b0, 1'b0};
    vecs[3]  = '{2'd0, 8'h80, 8'h80, 1'b1, 1'b0};
    vecs[4]  = '{2'd0, 8'h7F, 8'h7F, 1'b0, 1'b0};
    vecs[5]  = '{2'd1, 8'h80, OVF_RES, 1'b1, 1'b1};
    vecs[6]  = '{2'd2, 8'h80, OVF_RES, 1'b1, 1'b1};
    vecs[7]  = '{2'd2, 8'hFB, 8'h05, 1'b1, 1'b0};
    vecs[8]  = '{2'd2, 8'h05, 8'h05, 1'b0, 1'b0};
    vecs[9]  = '{2'd3, 8'h80, 8'h80, 1'b1, 1'b0};
    vecs[10] = '{2'd3, 8'hFF, 8'h01, 1'b1, 1'b0};
    vecs[11] = '{2'd3, 8'h01, 8'h01, 1'b0, 1'b0};
    vecs[12] = '{2'd1, 8'h01, 8'hFF, 1'b0, 1'b0};
    vecs[13] = '{2'd1, 8'h7F, 8'h81, 1'b0, 1'b0};
    vecs[14] = '{2'd0, 8'hFF, 8'hFF, 1'b1, 1'b0};

    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_mode = '0; out_ready = 1'b1;
    tick; tick;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_sign", out_sign, 0);
    chk("rst_out_ovf", out_ovf, 0);
    chk("rst_ovf_count", ovf_count, 0);
    chk("rst_in_ready", in_ready, 0);
    rst = 1'b0;
    #1;
    chk("post_rst_in_ready", in_ready, 1);

    // Table: back-to-back with out_ready high, one result per cycle
    exp_cnt = 2'd0;
    for (int i = 0; i <= 15; i++) begin
      if (i < 15) begin
        in_valid = 1'b1; in_mode = vecs[i].mode; in_data = vecs[i].data;
      end else begin
        in_valid = 1'b0;
      end
      tick;
      if (i >= 1) begin
        chk("tbl_valid", out_valid, 1);
        chk("tbl_data", out_data, vecs[i-1].exp_data);
        chk("tbl_sign", out_sign, vecs[i-1].exp_sign);
        chk("tbl_ovf", out_ovf, vecs[i-1].exp_ovf);
        chk("tbl_cnt", ovf_count, exp_cnt);
        if (vecs[i-1].exp_ovf && exp_cnt != 2'd3) exp_cnt++;
      end
    end
    tick;
    chk("tbl_drain_valid", out_valid, 0);
    chk("tbl_drain_cnt", ovf_count, exp_cnt);

    // Saturating counter: five overflows into a 2-bit counter
    do_reset;
    chk("sat_cnt0", ovf_count, 0);
    for (int c = 0; c < 8; c++) begin
      in_valid = (c < 5); in_mode = 2'd1; in_data = 8'h80;
      tick;
      if (c >= 2 && c <= 6)
        chk("sat_cnt", ovf_count, (c - 1 > 3) ? 16'd3 : 16'(c - 1));
    end

    // Both stages full under backpressure, then reset mid-stream
    do_reset;
    out_ready = 1'b0;
    in_valid = 1'b1; in_mode = 2'd1; in_data = 8'h05;
    tick;
    in_mode = 2'd2; in_data = 8'h80;
    tick;
    chk("full_in_ready", in_ready, 0);
    chk("full_out_valid", out_valid, 1);
    chk("full_out_data", out_data, 8'hFB);
    tick;
    chk("stall_out_data", out_data, 8'hFB);
    chk("stall_out_ovf", out_ovf, 0);
    chk("stall_in_ready", in_ready, 0);
    in_valid = 1'b0; rst = 1'b1;
    #1;
    chk("midrst_in_ready", in_ready, 0);
    tick;
    rst = 1'b0; out_ready = 1'b1;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_ovf_count", ovf_count, 0);
    chk("midrst_out_data", out_data, 0);
    for (int c = 0; c < 3; c++) begin
      tick;
      chk("no_stale", out_valid, 0);
    end

    // Random stream with random stalls against the scoreboard
    exp_cnt = 2'd0; occ = 0; stalled = 1'b0; held = '0;
    for (int c = 0; c < 400; c++) begin
      out_ready = ($urandom_range(0, 3) != 0);
      in_valid  = ($urandom_range(0, 3) != 0);
      in_mode   = 2'($urandom_range(0, 3));
      in_data   = ($urandom_range(0, 5) == 0) ? 8'h80 : 8'($urandom);
      #1;
      chk("rnd_cnt", ovf_count, exp_cnt);
      chk("rnd_in_ready", in_ready, (occ == 2 && !out_ready) ? 1'b0 : 1'b1);
      if (stalled) chk("rnd_stable", {out_ovf, out_sign, out_data}, held);
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          chk("rnd_unexpected_out", 1, 0);
        end else begin
          exp_r = q.pop_front();
          chk("rnd_out", {out_ovf, out_sign, out_data}, exp_r);
          if (exp_r[9] && exp_cnt != 2'd3) exp_cnt++;
          occ--;
        end
      end
      stalled = out_valid && !out_ready;
      held = {out_ovf, out_sign, out_data};
      if (in_valid && in_ready) begin
        q.push_back(ref_model(in_mode, in_data));
        occ++;
      end
      tick;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    budget = 20;
    while (q.size() != 0 && budget > 0) begin
      #1;
      if (out_valid) begin
        exp_r = q.pop_front();
        chk("drain_out", {out_ovf, out_sign, out_data}, exp_r);
        if (exp_r[9] && exp_cnt != 2'd3) exp_cnt++;
      end
      tick;
      budget--;
    end
    chk("drain_timeout", 16'(q.size()), 0);
    #1;
    chk("drain_cnt", ovf_count, exp_cnt);
    chk("drain_empty", out_valid, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/twos_comp_pipe.md
# twos_comp_pipe

Parametrised, pipelined two's-complement arithmetic unit for the turkey-counter datapath. Takes a signed WIDTH-bit count (net entries minus exits, which can go negative) and produces pass-through, negated, absolute or sign-magnitude results for the display and serial-report paths. Two registered stages with valid/ready flow control. Flags and counts the most-negative-value overflow case.

## Interface
Parameters:
- WIDTH, 8, data width in bits (≥2)
- OVF_CNT_W, 16, width of overflow event counter

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  reset, synchronous, active-high
- in_valid  in  1  input word present
- in_ready  out  1  unit accepts input this cycle
- in_data  in  WIDTH  signed operand
- in_mode  in  2  00 PASS, 01 NEG, 10 ABS, 11 SMAG
- out_valid  out  1  result present
- out_ready  in  1  consumer accepts result
- out_data  out  WIDTH  result (unsigned magnitude in SMAG)
- out_sign  out  1  sign of operand (in_data MSB), all modes
- out_ovf  out  1  result not representable (see Operation)
- ovf_count  out  OVF_CNT_W  saturating count of overflow results delivered

## Operation
- Stage 1 (S1): captures in_data, in_mode on input handshake (in_valid && in_ready).
- Stage 2 (S2): computes from S1 and holds the result on out_*.
- PASS: out_data = in_data, out_ovf = 0.
- NEG: out_data = ~in_data + 1, truncated to WIDTH bits. out_ovf = 1 iff in_data = MIN (1 followed by WIDTH-1 zeros).
- ABS: out_data = in_data if MSB = 0, otherwise NEG. out_ovf = 1 iff in_data = MIN.
- SMAG: out_data = unsigned |in_data|, out_ovf always 0. MIN yields 2^(WIDTH-1), which is representable as unsigned.
- Without saturation, overflowing NEG/ABS return MIN (wrap).
- ovf_count increments on each output handshake with out_ovf = 1. It holds at all-ones.
- Stage advance:
  - S2 loads when S1 is valid and (S2 is empty or out_ready).
  - S1 loads when in_valid and (S1 is empty or S1 is advancing).
  - in_ready = !rst && (!S1_valid || S1_advance).
- Full throughput: one result per cycle when out_ready is held high.

## Timing
- Latency: input accepted at edge N gives out_valid high after edge N+1, with no stall.
- Backpressure: while out_valid && !out_ready, out_data, out_sign and out_ovf are stable.
- With both stages full and out_ready low, in_ready is 0. No word is lost or duplicated.
- Simultaneous output drain and input accept in the same cycle: both complete, and occupancy is unchanged.
- Reset (any cycle, including mid-stream):
  - Clears both valids, out_data, out_sign, out_ovf and ovf_count to 0.
  - In-flight words are discarded.
  - in_ready is 0 while rst is high and 1 on the first cycle after reset.
- ovf_count updates on the same edge as the output handshake. A new value is visible the next cycle.

## Configuration
- TWOS_SAT_EN defined: overflowing NEG/ABS return MAX (0 followed by WIDTH-1 ones) instead of MIN. out_ovf is still 1 and ovf_count still increments. PASS and SMAG are unaffected.
- TWOS_SAT_EN undefined: wrap behaviour as in Operation. There is no saturation logic.

## Structure
- Package twos_pkg holds:
  - mode typedef (2-bit enum) and constants MODE_PASS, MODE_NEG, MODE_ABS, MODE_SMAG
  - width-parametric MIN/MAX helper functions
- Sub-module pipe_stage: one valid/ready register slice, parametrised payload width. Instantiated twice: S1 for operand+mode, S2 for result+sign+ovf.

## Test plan
- WIDTH=8, out_ready=1, NEG on 0x05, 0xFB, 0x00 back-to-back: outputs 0xFB, 0x05, 0x00 on consecutive cycles from edge 2, out_ovf = 0.
- NEG and ABS on 0x80: out_data = 0x80 (0x7F with TWOS_SAT_EN), out_ovf = 1, ovf_count goes 0→1→2.
- SMAG on 0x80 and 0xFF: out_data = 0x80 and 0x01, out_sign = 1, out_ovf = 0.
- Random input stream with random out_ready stalls: output sequence equals the reference model, out_* stable during stalls, in_ready = 0 when both stages are full.
- rst asserted for 1 cycle with both stages full: out_valid = 0 and ovf_count = 0 next cycle, and no stale word appears afterwards.
- OVF_CNT_W=2 with five overflowing results: ovf_count reads 1, 2, 3, 3, 3.
